// File: rtl/reg_bus_initiator_pkg.sv
// Shared peripheral-bus definitions: bridge FSM state encoding, default
// timeout read data and the width of the response watchdog counter.
package reg_bus_initiator_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

   localparam int TCNT_W = 8;

endpackage

// File: rtl/reg_bus_initiator.sv
// Wishbone classic slave to peripheral register bus initiator.
// One transaction is outstanding at a time. A watchdog turns a missing
// reg_ack into a Wishbone error so a dead responder cannot hang the master.
//
// Handshake: a Wishbone request is taken when wbs_cyc_i & wbs_stb_i are high
// in IDLE. reg_cs then stays high, with reg_* fields frozen, until reg_ack is
// sampled high, the watchdog expires, or the master drops wbs_cyc_i (abort).
// Completion is a single-cycle wbs_ack_o or wbs_err_o pulse with wbs_dat_o
// valid in that same cycle. An abort produces no pulse. reg_ack outside of
// REQ is a stale response and is ignored.
module reg_bus_initiator
   import reg_bus_initiator_pkg::*;
#(
   parameter int          AW        = 11,
   parameter int          TIMEOUT   = 255,  // legal range 1..255
   parameter logic [31:0] ERR_RDATA = DEFAULT_ERR_RDATA
) (
   input  logic          mclk,
   input  logic          s_reset,
   input  logic          wbs_cyc_i,
   input  logic          wbs_stb_i,
   input  logic          wbs_we_i,
   input  logic [AW-1:0] wbs_adr_i,
   input  logic [31:0]   wbs_dat_i,
   input  logic [3:0]    wbs_sel_i,
   output logic [31:0]   wbs_dat_o,
   output logic          wbs_ack_o,
   output logic          wbs_err_o,
   output logic          reg_cs,
   output logic          reg_wr,
   output logic [AW-1:0] reg_addr,
   output logic [31:0]   reg_wdata,
   output logic [3:0]    reg_be,
   input  logic [31:0]   reg_rdata,
   input  logic          reg_ack
);

   // Count value seen on the TIMEOUT-th REQ cycle (count starts at 0).
   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);
   localparam logic [TCNT_W-1:0] TCNT_MAX  = '1;

   state_t            state;
   logic [TCNT_W-1:0] tcnt;
   logic              timeout_hit;

   assign timeout_hit = (tcnt == TCNT_LAST);

   // Bridge FSM; every bus-facing output is a register updated here.
   always_ff @(posedge mclk or posedge s_reset) begin
      if (s_reset) begin
         state     <= IDLE;
         tcnt      <= '0;
         reg_cs    <= 1'b0;
         reg_wr    <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         reg_be    <= '0;
         wbs_dat_o <= '0;
         wbs_ack_o <= 1'b0;
         wbs_err_o <= 1'b0;
      end else begin
         // Completion strobes are single-cycle unless set again below.
         wbs_ack_o <= 1'b0;
         wbs_err_o <= 1'b0;
         case (state)
            IDLE: begin
               if (wbs_cyc_i && wbs_stb_i) begin
                  reg_cs    <= 1'b1;
                  reg_wr    <= wbs_we_i;
                  reg_addr  <= wbs_adr_i;
                  reg_wdata <= wbs_dat_i;
                  reg_be    <= wbs_sel_i;
                  tcnt      <= '0;
                  state     <= REQ;
               end
            end
            REQ: begin
               // Abort beats a response, and a response beats the watchdog.
               if (!wbs_cyc_i) begin
                  reg_cs <= 1'b0;
                  state  <= IDLE;
               end else if (reg_ack) begin
                  reg_cs    <= 1'b0;
                  wbs_dat_o <= reg_wr ? 32'h0 : reg_rdata;
                  wbs_ack_o <= 1'b1;
                  state     <= RESP;
               end else if (timeout_hit) begin
                  reg_cs    <= 1'b0;
                  wbs_dat_o <= ERR_RDATA;
                  wbs_err_o <= 1'b1;
                  state     <= RESP;
               end else if (tcnt != TCNT_MAX) begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            RESP: begin
               // The master drops stb on seeing ack/err, so stb is not looked at here.
               state <= IDLE;
            end
            default: begin
               reg_cs <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule
